gshare_predictor: RTL and testbench

- Parametrised branch direction predictor: a table of 2^INDEX_BITS saturating counters, each CTR_BITS wide, plus a global history register (GHR).
- Fetch stage reads a prediction combinationally from pc_f; execute stage trains the table when the branch resolves.
- MODE selects bimodal (PC-indexed) or gshare (PC XOR GHR) indexing.
- Built-in saturating counters track resolved branches and mispredictions for performance measurement.

---
 rtl/gshare_predictor.sv | 96 +++++++++
 tb/tb_gshare_predictor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// Branch direction predictor: a table of saturating counters indexed by the PC,
// optionally XORed with a non-speculative global history, plus branch/mispredict statistics.
module gshare_predictor #(
    parameter int CTR_BITS   = 2,
    parameter int INDEX_BITS = 6,
    parameter int GHR_BITS   = 6,
    parameter int MODE       = 1,
    parameter int STAT_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           pc_f,
    output logic                  bp_f,
    output logic [INDEX_BITS-1:0] idx_f,
    input  logic                  update_e,
    input  logic [INDEX_BITS-1:0] idx_e,
    input  logic                  taken_e,
    input  logic                  pred_e,
    output logic [STAT_BITS-1:0]  branch_cnt,
    output logic [STAT_BITS-1:0]  mispred_cnt
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
    localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

    logic [CTR_BITS-1:0]   table_q [ENTRIES];
    logic [CTR_BITS-1:0]   ctr_d;
    logic [GHR_BITS-1:0]   ghr_q, ghr_d;
    logic [STAT_BITS-1:0]  branch_q, branch_d;
    logic [STAT_BITS-1:0]  mispred_q, mispred_d;
    logic [INDEX_BITS-1:0] pcIdx;
    logic [INDEX_BITS-1:0] ghrExt;
    logic                  unusedBits;

    // Byte-offset and upper PC bits never contribute to the index.
    assign pcIdx      = pc_f[INDEX_BITS+1:2];
    assign unusedBits = ^{pc_f[31:INDEX_BITS+2], pc_f[1:0], ghrExt};

    always_comb begin
        ghrExt                 = '0;
        ghrExt[GHR_BITS-1:0]   = ghr_q;
    end

    generate
        if (MODE == 0) begin : gBimodal
            assign idx_f = pcIdx;
        end else begin : gGshare
            assign idx_f = pcIdx ^ ghrExt;
        end
    endgenerate

    // Reads the registered table, so a same-cycle update is seen only next cycle.
    assign bp_f        = table_q[idx_f][CTR_BITS-1];
    assign branch_cnt  = branch_q;
    assign mispred_cnt = mispred_q;

    always_comb begin
        ctr_d = table_q[idx_e];
        if (taken_e) begin
            if (ctr_d != CTR_MAX) ctr_d = ctr_d + CTR_BITS'(1);
        end else begin
            if (ctr_d != '0) ctr_d = ctr_d - CTR_BITS'(1);
        end
    end

    generate
        if (GHR_BITS == 1) begin : gGhrOne
            assign ghr_d = taken_e;
        end else begin : gGhrShift
            assign ghr_d = {ghr_q[GHR_BITS-2:0], taken_e};
        end
    endgenerate

    always_comb begin
        branch_d  = branch_q;
        mispred_d = mispred_q;
        if (branch_q != STAT_MAX) branch_d = branch_q + STAT_BITS'(1);
        if ((pred_e != taken_e) && (mispred_q != STAT_MAX)) mispred_d = mispred_q + STAT_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= '0;
            ghr_q     <= '0;
            branch_q  <= '0;
            mispred_q <= '0;
        end else if (update_e) begin
            table_q[idx_e] <= ctr_d;
            ghr_q          <= ghr_d;
            branch_q       <= branch_d;
            mispred_q      <= mispred_d;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: a bimodal instance (3-bit stats) and a gshare instance
// share one directed stimulus stream and are checked against an abstract model.
module tb_gshare_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] pc_f;
    logic        update_e;
    logic [5:0]  idx_e;
    logic        taken_e;
    logic        pred_e;

    logic        bpB, bpG;
    logic [5:0]  idxB, idxG;
    logic [2:0]  bcB, mcB;
    logic [15:0] bcG, mcG;

    int checks = 0;
    int errors = 0;
    logic checkEn = 1'b0;

    int mCtrB [64];
    int mCtrG [64];
    int mGhr;
    int mBcB, mMcB, mBcG, mMcG;
    int pidx, gidx;

    gshare_predictor #(.MODE(0), .STAT_BITS(3)) dutB (
        .clk(clk), .reset(reset), .pc_f(pc_f), .bp_f(bpB), .idx_f(idxB),
        .update_e(update_e), .idx_e(idx_e), .taken_e(taken_e), .pred_e(pred_e),
        .branch_cnt(bcB), .mispred_cnt(mcB)
    );

    gshare_predictor #(.MODE(1)) dutG (
        .clk(clk), .reset(reset), .pc_f(pc_f), .bp_f(bpG), .idx_f(idxG),
        .update_e(update_e), .idx_e(idx_e), .taken_e(taken_e), .pred_e(pred_e),
        .branch_cnt(bcG), .mispred_cnt(mcG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int satInc(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    function automatic int satDec(input int v);
        return (v <= 0) ? 0 : v - 1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change just after a rising edge; returns mid-cycle with outputs settled.
    task automatic applyStimulus(input logic rst, input logic [31:0] pc, input logic upd,
                                 input logic [5:0] idx, input logic tk, input logic pr);
        @(posedge clk);
        #1;
        reset = rst; pc_f = pc; update_e = upd; idx_e = idx; taken_e = tk; pred_e = pr;
        @(negedge clk);
        #1;
    endtask

    // Abstract model: counters as integers, history as a masked integer shift.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                mCtrB[i] <= 0;
                mCtrG[i] <= 0;
            end
            mGhr <= 0;
            mBcB <= 0; mMcB <= 0; mBcG <= 0; mMcG <= 0;
        end else if (update_e) begin
            mCtrB[idx_e] <= taken_e ? satInc(mCtrB[idx_e], 3) : satDec(mCtrB[idx_e]);
            mCtrG[idx_e] <= taken_e ? satInc(mCtrG[idx_e], 3) : satDec(mCtrG[idx_e]);
            mGhr <= ((mGhr << 1) | int'(taken_e)) & 63;
            mBcB <= satInc(mBcB, 7);
            mBcG <= satInc(mBcG, 65535);
            if (pred_e != taken_e) begin
                mMcB <= satInc(mMcB, 7);
                mMcG <= satInc(mMcG, 65535);
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            pidx = int'(pc_f[7:2]);
            gidx = pidx ^ mGhr;
            checkOutput("cmpIdxB", int'(idxB), pidx);
            checkOutput("cmpBpB", int'(bpB), int'(mCtrB[pidx] >= 2));
            checkOutput("cmpIdxG", int'(idxG), gidx);
            checkOutput("cmpBpG", int'(bpG), int'(mCtrG[gidx] >= 2));
            checkOutput("cmpBranchB", int'(bcB), mBcB);
            checkOutput("cmpMispredB", int'(mcB), mMcB);
            checkOutput("cmpBranchG", int'(bcG), mBcG);
            checkOutput("cmpMispredG", int'(mcG), mMcG);
        end
    end

    initial begin
        reset = 1'b1; pc_f = '0; update_e = 1'b0; idx_e = '0; taken_e = 1'b0; pred_e = 1'b0;
        applyStimulus(1'b1, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
        checkEn = 1'b1;
        checkOutput("rstBranchB", int'(bcB), 0);
        checkOutput("rstMispredB", int'(mcB), 0);
        checkOutput("rstBranchG", int'(bcG), 0);
        checkOutput("rstMispredG", int'(mcG), 0);
        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b0, 32'(i * 4), 1'b0, 6'd0, 1'b0, 1'b0);
            checkOutput("rstSweepBpB", int'(bpB), 0);
            checkOutput("rstSweepBpG", int'(bpG), 0);
            checkOutput("rstSweepIdxB", int'(idxB), i);
        end

        // Bimodal training and saturation on index 16
        applyStimulus(1'b0, 32'h40, 1'b1, 6'd16, 1'b1, 1'b0);
        checkOutput("bimodalIdx", int'(idxB), 16);
        checkOutput("bimodalZero", int'(bpB), 0);
        applyStimulus(1'b0, 32'h40, 1'b1, 6'd16, 1'b1, 1'b0);
        checkOutput("bimodalOne", int'(bpB), 0);
        applyStimulus(1'b0, 32'h40, 1'b0, 6'd0, 1'b0, 1'b0);
        checkOutput("bimodalTwo", int'(bpB), 1);
        repeat (4) applyStimulus(1'b0, 32'h40, 1'b1, 6'd16, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h40, 1'b0, 6'd0, 1'b0, 1'b0);
        checkOutput("satHigh", int'(bpB), 1);
        applyStimulus(1'b0, 32'h40, 1'b1, 6'd16, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h40, 1'b0, 6'd0, 1'b0, 1'b0);
        checkOutput("satDown1", int'(bpB), 1);
        applyStimulus(1'b0, 32'h40, 1'b1, 6'd16, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h40, 1'b0, 6'd0, 1'b0, 1'b0);
        checkOutput("satDown2", int'(bpB), 0);

        // Gshare: history T,T,N gives 6'b000110
        applyStimulus(1'b1, 32'h40, 1'b0, 6'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h40, 1'b1, 6'd40, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h40, 1'b1, 6'd40, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h40, 1'b1, 6'd40, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h40, 1'b0, 6'd0, 1'b0, 1'b0);
        checkOutput("gshareIdx22", int'(idxG), 22);
        checkOutput("gshareBimodalIdx", int'(idxB), 16);
        checkOutput("gshareBpCold", int'(bpG), 0);
        applyStimulus(1'b0, 32'h40, 1'b1, 6'd22, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h40, 1'b1, 6'd22, 1'b1, 1'b0);
        // History is now 6'b011011; pc 0x34 maps back onto entry 22
        applyStimulus(1'b0, 32'h34, 1'b0, 6'd0, 1'b0, 1'b0);
        checkOutput("gshareIdxAgain", int'(idxG), 22);
        checkOutput("gshareBpTrained", int'(bpG), 1);
        checkOutput("gshareBimodalUntouched", int'(bpB), 0);
        applyStimulus(1'b0, 32'h2C, 1'b0, 6'd0, 1'b0, 1'b0);
        checkOutput("gshareIdx16", int'(idxG), 16);
        checkOutput("gshareEntry16", int'(bpG), 0);

        // Read/write collision on entry 5
        applyStimulus(1'b0, 32'h14, 1'b1, 6'd5, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h14, 1'b1, 6'd5, 1'b1, 1'b0);
        checkOutput("collisionIdx", int'(idxB), 5);
        checkOutput("collisionSame", int'(bpB), 0);
        applyStimulus(1'b0, 32'h14, 1'b0, 6'd0, 1'b0, 1'b0);
        checkOutput("collisionNext", int'(bpB), 1);

        // Back-to-back updates, repeated indices, mixed outcomes
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 32'(i * 12), 1'b1, 6'((i % 3) + 20), (i % 5) != 0, (i % 2) == 1);
        end
        applyStimulus(1'b0, 32'h50, 1'b0, 6'd0, 1'b0, 1'b0);

        // Statistics saturation and reset colliding with an update
        applyStimulus(1'b1, 32'h1C, 1'b0, 6'd0, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 32'h1C, 1'b1, 6'd7, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h1C, 1'b0, 6'd0, 1'b0, 1'b0);
        checkOutput("statBranchSat", int'(bcB), 7);
        checkOutput("statMispredSat", int'(mcB), 7);
        checkOutput("statBranchWide", int'(bcG), 10);
        checkOutput("statMispredWide", int'(mcG), 10);
        applyStimulus(1'b0, 32'h1C, 1'b1, 6'd7, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h1C, 1'b1, 6'd7, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h1C, 1'b1, 6'd7, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h1C, 1'b0, 6'd0, 1'b0, 1'b0);
        checkOutput("rstMidBranchB", int'(bcB), 0);
        checkOutput("rstMidMispredB", int'(mcB), 0);
        checkOutput("rstMidBranchG", int'(bcG), 0);
        checkOutput("rstMidGhr", int'(idxG), 7);
        applyStimulus(1'b0, 32'h1C, 1'b1, 6'd7, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h1C, 1'b0, 6'd0, 1'b0, 1'b0);
        checkOutput("resetIgnoresUpdate", int'(bpB), 0);
        checkOutput("postRstBranchG", int'(bcG), 1);

        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
